// File: rtl/dma_pkg.sv
// Shared DMA definitions: FSM state encoding, AXI constants and the
// byte-lane strobe helper used by both DMA directions.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ADDR_DATA = 3'd2,
        ST_RESP      = 3'd3,
        ST_DONE      = 3'd4
    } dma_state_e;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Lane enables for one 32-bit beat: the first beat starts at lane off,
    // the last beat ends below lane end_off (end_off==0 means a full word).
    function automatic logic [3:0] byte_strobe(
        input logic [1:0] off,
        input logic [1:0] end_off,
        input logic       first,
        input logic       last
    );
        logic [3:0] head;
        logic [3:0] tail;
        head = first ? 4'(4'b1111 << off) : 4'b1111;
        tail = (!last || end_off == 2'd0) ? 4'b1111 : 4'((5'd1 << end_off) - 5'd1);
        return head & tail;
    endfunction

endpackage

// File: rtl/dma_wr_align.sv
// Realigns the packed source stream onto the destination byte offset.
//   cur, prev : current and previous source words (LSB-first bytes)
//   off       : destination byte offset within a word
//   first/last: beat position within the transfer
//   end_off   : (off + length) mod 4
//   wdata_c   : beat data, wstrb_c : beat lane enables
module dma_wr_align
    import dma_pkg::*;
(
    input  logic [31:0] cur,
    input  logic [31:0] prev,
    input  logic [1:0]  off,
    input  logic        first,
    input  logic        last,
    input  logic [1:0]  end_off,
    output logic [31:0] wdata_c,
    output logic [3:0]  wstrb_c
);

    logic [5:0] shamt_c;

    // Shift by 8*(4-off); off==0 shifts the whole prev word out, leaving cur.
    always_comb begin
        shamt_c = 6'({3'd4 - {1'b0, off}, 3'b000});
        wdata_c = 32'({cur, prev} >> shamt_c);
        wstrb_c = byte_strobe(off, end_off, first, last);
    end

endmodule

// File: rtl/dma_write.sv
// AXI4-Lite write master: drains packed source words and writes `length`
// bytes at any byte address, one single-word transaction outstanding.
//   trigger/length/dest_addr : transfer request (sampled in IDLE)
//   busy/done/error          : status (error is sticky until next trigger)
//   in_data/in_valid/in_ready: packed source word stream
//   AW*/W*/B*                : AXI4-Lite write channels
module dma_write
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic [LEN_W-1:0]      length,
    input  logic [ADDR_W-1:0]     dest_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic                  AWVALID,
    output logic [2:0]            AWPROT,
    input  logic                  AWREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SUM_W  = LEN_W + 1;

    dma_state_e          state_q, state_d;
    logic                busy_d, done_d, error_d, in_ready_d;
    logic                awvalid_d, wvalid_d, bready_d;
    logic [ADDR_W-1:0]   awaddr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [STRB_W-1:0]   wstrb_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [1:0]          off_q, off_d;
    logic [1:0]          end_q, end_d;
    logic [LEN_W-1:0]    beats_q, beats_d;
    logic [LEN_W-1:0]    words_q, words_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic [DATA_W-1:0]   cur_q, cur_d;
    logic                issued_q, issued_d;
    logic                first_c, last_c;
    logic [DATA_W-1:0]   align_data_c;
    logic [STRB_W-1:0]   align_strb_c;

    assign AWPROT  = AXI_PROT_DEFAULT;
    assign first_c = (beat_q == '0);
    assign last_c  = (beat_q == beats_q - LEN_W'(1));

    dma_wr_align u_align (
        .cur     (cur_q),
        .prev    (prev_q),
        .off     (off_q),
        .first   (first_c),
        .last    (last_c),
        .end_off (end_q),
        .wdata_c (align_data_c),
        .wstrb_c (align_strb_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            in_ready <= 1'b0;
            AWVALID  <= 1'b0;
            WVALID   <= 1'b0;
            BREADY   <= 1'b0;
            AWADDR   <= '0;
            WDATA    <= '0;
            WSTRB    <= '0;
            base_q   <= '0;
            off_q    <= '0;
            end_q    <= '0;
            beats_q  <= '0;
            words_q  <= '0;
            beat_q   <= '0;
            prev_q   <= '0;
            cur_q    <= '0;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
            in_ready <= in_ready_d;
            AWVALID  <= awvalid_d;
            WVALID   <= wvalid_d;
            BREADY   <= bready_d;
            AWADDR   <= awaddr_d;
            WDATA    <= wdata_d;
            WSTRB    <= wstrb_d;
            base_q   <= base_d;
            off_q    <= off_d;
            end_q    <= end_d;
            beats_q  <= beats_d;
            words_q  <= words_d;
            beat_q   <= beat_d;
            prev_q   <= prev_d;
            cur_q    <= cur_d;
            issued_q <= issued_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy;
        done_d     = 1'b0;
        error_d    = error;
        in_ready_d = 1'b0;
        awvalid_d  = AWVALID;
        wvalid_d   = WVALID;
        bready_d   = BREADY;
        awaddr_d   = AWADDR;
        wdata_d    = WDATA;
        wstrb_d    = WSTRB;
        base_d     = base_q;
        off_d      = off_q;
        end_d      = end_q;
        beats_d    = beats_q;
        words_d    = words_q;
        beat_d     = beat_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        issued_d   = issued_q;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    if (length == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        base_d     = {dest_addr[ADDR_W-1:2], 2'b00};
                        off_d      = dest_addr[1:0];
                        end_d      = 2'(dest_addr[1:0] + length[1:0]);
                        beats_d    = LEN_W'((SUM_W'(dest_addr[1:0]) + SUM_W'(length) + SUM_W'(3)) >> 2);
                        words_d    = LEN_W'((SUM_W'(length) + SUM_W'(3)) >> 2);
                        beat_d     = '0;
                        prev_d     = '0;
                        cur_d      = '0;
                        in_ready_d = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
            end

            // Pull the next source word, or shift in zero for the trailing beat.
            ST_FETCH: begin
                if (words_q != '0) begin
                    if (in_valid && in_ready) begin
                        prev_d  = cur_q;
                        cur_d   = in_data;
                        words_d = words_q - LEN_W'(1);
                        state_d = ST_ADDR_DATA;
                    end else begin
                        in_ready_d = 1'b1;
                    end
                end else begin
                    prev_d  = cur_q;
                    cur_d   = '0;
                    state_d = ST_ADDR_DATA;
                end
            end

            // Launch AW and W together; each retires on its own handshake.
            ST_ADDR_DATA: begin
                if (!issued_q) begin
                    awaddr_d  = base_q + ADDR_W'({beat_q, 2'b00});
                    wdata_d   = align_data_c;
                    wstrb_d   = align_strb_c;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    issued_d  = 1'b1;
                end else begin
                    if (AWVALID && AWREADY) awvalid_d = 1'b0;
                    if (WVALID && WREADY)   wvalid_d  = 1'b0;
                    if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
                        issued_d = 1'b0;
                        bready_d = 1'b1;
                        state_d  = ST_RESP;
                    end
                end
            end

            // A failing response aborts the remaining beats.
            ST_RESP: begin
                if (BVALID && BREADY) begin
                    bready_d = 1'b0;
                    if (BRESP != RESP_OKAY) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (last_c) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d     = beat_q + LEN_W'(1);
                        in_ready_d = (words_q != '0);
                        state_d    = ST_FETCH;
                    end
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule
